// File: rtl/remote_pkg.sv
// Shared types and NEC protocol constants for the IR transmitter.
package remote_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_MARK,
    ST_LEAD_SPACE,
    ST_BIT_MARK,
    ST_BIT_SPACE,
    ST_STOP_MARK
  } state_e;

  localparam int LEAD_MARK_T    = 16;
  localparam int LEAD_SPACE_T   = 8;
  localparam int REPEAT_SPACE_T = 4;
  localparam int BIT_MARK_T     = 1;
  localparam int ONE_SPACE_T    = 3;
  localparam int ZERO_SPACE_T   = 1;
  localparam int STOP_T         = 1;
  localparam int FRAME_BITS     = 32;
  localparam int BIT_CNT_W      = $clog2(FRAME_BITS);

  // Length in T units of the given state for the current frame and bit.
  function automatic logic [4:0] state_units(state_e s, logic rpt, logic bit_val);
    case (s)
      ST_LEAD_MARK:  return 5'(LEAD_MARK_T);
      ST_LEAD_SPACE: return rpt ? 5'(REPEAT_SPACE_T) : 5'(LEAD_SPACE_T);
      ST_BIT_MARK:   return 5'(BIT_MARK_T);
      ST_BIT_SPACE:  return bit_val ? 5'(ONE_SPACE_T) : 5'(ZERO_SPACE_T);
      ST_STOP_MARK:  return 5'(STOP_T);
      default:       return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Free-running carrier counter; 'carrier' is the phase the next cycle will have,
// so the caller can register it alongside its own next-state outputs.
module ir_carrier_gen #(
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 439
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic restart,
  output logic carrier
);

  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in always_comb gets a default first, otherwise
  // a missed branch silently infers a latch.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || cnt_q == CW'(CARRIER_DIV - 1)) cnt_d = '0;
  end

  assign carrier = 32'(cnt_d) < CARRIER_HIGH;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/remote_send.sv
// NEC infrared transmitter: FSM, T-unit timing, 32-bit shift register and
// registered envelope/LED outputs.
module remote_send
  import remote_pkg::*;
#(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 439
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tx_start,
  input  logic       tx_repeat,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_cmd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       ir_env,
  output logic       ir_out
);

  localparam int CYC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [4:0]           unit_q, unit_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic [31:0]          shift_q, shift_d;
  logic                 rpt_q, rpt_d;
  logic                 env_q, env_d, out_q, out_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 tick, last_unit, restart, carrier;
  logic [4:0]           dur;

  assign tick      = cyc_q == CYC_W'(UNIT_CYCLES - 1);
  assign dur       = state_units(state_q, rpt_q, shift_q[0]);
  assign last_unit = tick && (unit_q == dur - 5'd1);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    unit_d  = unit_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rpt_d   = rpt_q;
    done_d  = 1'b0;

    if (state_q == ST_IDLE) begin
      cyc_d  = '0;
      unit_d = '0;
      bit_d  = '0;
      // Full frame wins when both requests are present.
      if (tx_start) begin
        state_d = ST_LEAD_MARK;
        shift_d = {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
        rpt_d   = 1'b0;
      end else if (tx_repeat) begin
        state_d = ST_LEAD_MARK;
        rpt_d   = 1'b1;
      end
    end else begin
      cyc_d = tick ? '0 : cyc_q + 1'b1;
      if (tick) unit_d = unit_q + 1'b1;
      if (last_unit) begin
        unit_d = '0;
        case (state_q)
          ST_LEAD_MARK:  state_d = ST_LEAD_SPACE;
          ST_LEAD_SPACE: state_d = rpt_q ? ST_STOP_MARK : ST_BIT_MARK;
          ST_BIT_MARK:   state_d = ST_BIT_SPACE;
          ST_BIT_SPACE: begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
            state_d = (bit_q == BIT_CNT_W'(FRAME_BITS - 1)) ? ST_STOP_MARK : ST_BIT_MARK;
          end
          ST_STOP_MARK: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Outputs are registered from next-state values so they line up with state_q.
  assign env_d   = (state_d == ST_LEAD_MARK) || (state_d == ST_BIT_MARK) ||
                   (state_d == ST_STOP_MARK);
  assign restart = env_d && (state_d != state_q);
  assign out_d   = env_d && carrier;
  assign busy_d  = state_d != ST_IDLE;

  ir_carrier_gen #(
    .CARRIER_DIV  (CARRIER_DIV),
    .CARRIER_HIGH (CARRIER_HIGH)
  ) u_carrier (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .restart   (restart),
    .carrier   (carrier)
  );

  // NOTE: the shift register is an ordinary flop vector, not a RAM, so it is
  // reset with everything else and no stale data can leak into a new frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      unit_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rpt_q   <= 1'b0;
      env_q   <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rpt_q   <= rpt_d;
      env_q   <= env_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ir_env  = env_q;
  assign ir_out  = out_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
